instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/mips_pkg.sv | 15 +
 rtl/ifetch_stall_counter.sv | 17 +
 rtl/instr_fetch.sv | 97 +++++++++
 tb/tb_instr_fetch.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: FSM states, opcode field position, default reset PC.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifetch_stall_counter.sv
// Saturating count of cycles in which decode had no instruction available.
module ifetch_stall_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        starved,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (starved && (count != '1)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch stage with redirect handling.
// Optional decode-starvation counter enabled by IFETCH_STALL_CNT_EN.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [5:0]  out_opcode,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] stall_cnt
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  drain_addr;
  logic [31:0]  redirect_aligned;

  assign redirect_aligned = redirect_pc & ~32'h3;

  // Request is gated by reset so nothing is issued while rst_n is low,
  // yet it is up immediately once reset releases.
  assign imem_req   = rst_n && (state != HOLD);
  assign imem_addr  = (state == DRAIN) ? drain_addr : pc;
  assign out_opcode = out_instr[OPCODE_MSB:OPCODE_LSB];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drain_addr <= '0;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_pc     <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ack && redirect_valid) begin
            pc <= redirect_aligned;
          end else if (imem_ack) begin
            out_instr <= imem_rdata;
            out_pc    <= pc;
            pc        <= pc + 32'd4;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (redirect_valid) begin
            // The outstanding request must still complete at its old address.
            drain_addr <= pc;
            pc         <= redirect_aligned;
            state      <= DRAIN;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            out_valid <= 1'b0;
            pc        <= redirect_aligned;
            state     <= FETCH;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= FETCH;
          end
        end
        DRAIN: begin
          if (redirect_valid) begin
            pc <= redirect_aligned;
          end
          if (imem_ack) begin
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  ifetch_stall_counter u_stall_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .starved (!out_valid),
    .count   (stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: transaction-level reference model, randomized traffic.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [5:0]  out_opcode;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] stall_cnt;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  item_t       exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model: next stream address, one abandoned request, presented instruction.
  logic [31:0] m_pc;
  logic        m_stale;
  logic [31:0] m_stale_addr;
  logic        m_hold;
  logic [31:0] m_stall;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_opcode     (out_opcode),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0000_0000;
    m_stale = 1'b0;
    m_hold  = 1'b0;
    m_stall = '0;
    m_stale_addr = '0;
    exp_q.delete();
  endtask

  task automatic model_update(input logic a, input logic r, input logic v, input logic [31:0] ra);
    logic [31:0] ra_al;
    ra_al = {ra[31:2], 2'b00};
    if (!m_hold && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (m_hold) begin
      if (v) m_pc = ra_al;
      if (v || r) m_hold = 1'b0;
    end else if (m_stale) begin
      if (v) m_pc = ra_al;
      if (a) m_stale = 1'b0;
    end else if (a && !v) begin
      exp_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
      m_pc   = m_pc + 32'd4;
      m_hold = 1'b1;
    end else if (v) begin
      if (!a) begin
        m_stale      = 1'b1;
        m_stale_addr = m_pc;
      end
      m_pc = ra_al;
    end
  endtask

  task automatic step(input logic a, input logic r, input logic v, input logic [31:0] ra);
    imem_ack       = a && !m_hold;
    out_ready      = r;
    redirect_valid = v;
    redirect_pc    = ra;
    @(posedge clk);
    #1;
    model_update(imem_ack, r, v, ra);
  endtask

  task automatic to_fetch();
    int unsigned n;
    n = 0;
    while ((m_hold || m_stale) && n < 20) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    if (m_hold || m_stale) begin
      n_vec++;
      n_bad++;
      $display("FAIL to_fetch: still busy after %0d cycles", n);
    end
  endtask

  // Monitor: compares the request side and the presented instruction every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("imem_req", {31'b0, imem_req}, {31'b0, !m_hold});
        if (!m_hold) check("imem_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
        check("out_valid", {31'b0, out_valid}, {31'b0, m_hold});
`ifdef IFETCH_STALL_CNT_EN
        check("stall_cnt", stall_cnt, m_stall);
`else
        check("stall_cnt", stall_cnt, 32'h0);
`endif
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL out_unexpected: got pc %h, expected nothing", out_pc);
          end else begin
            check("out_pc", out_pc, exp_q[0].pc);
            check("out_instr", out_instr, exp_q[0].instr);
            check("out_opcode", {26'b0, out_opcode}, {26'b0, exp_q[0].instr[31:26]});
            if (out_ready || redirect_valid) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    imem_ack = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_stall", stall_cnt, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Starve decode for 10 cycles right after reset.
    repeat (10) step(1'b0, 1'b1, 1'b0, 32'h0);
`ifdef IFETCH_STALL_CNT_EN
    check("stall_ge10", {31'b0, stall_cnt >= 32'd10}, 32'h1);
`else
    check("stall_off", stall_cnt, 32'h0);
`endif

    // Back-to-back fetch: 0x0, 0x4, 0x8 ...
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Decode back-pressure while holding.
    to_fetch();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect without ack, ack delayed 3 cycles, then drain.
    to_fetch();
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("after_drain", imem_addr, 32'h0000_0100);
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect coincident with ack; low address bits ignored.
    to_fetch();
    step(1'b1, 1'b1, 1'b1, 32'h0000_0203);
    check("coincident", imem_addr, 32'h0000_0200);
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Wrap-around at the top of the address space.
    to_fetch();
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("wrap", imem_addr, 32'h0000_0000);
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect while holding, with and without a coincident handshake.
    to_fetch();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0400);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0800);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      logic [31:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) == 0, ra);
    end

    // Reset in the middle of an unacknowledged request: no drain afterwards.
    to_fetch();
    step(1'b0, 1'b1, 1'b1, 32'h0000_1000);
    rst_n = 1'b0;
    imem_ack = 1'b0;
    redirect_valid = 1'b0;
    model_reset();
    @(negedge clk);
    check("midrst_req", {31'b0, imem_req}, 32'h0);
    check("midrst_valid", {31'b0, out_valid}, 32'h0);
    check("midrst_stall", stall_cnt, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);

    check("queue_empty", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
